shapool_job_ctrl: RTL and testbench

//  Host-side end of the shapool job/result interface. Deserialises a 45-byte job frame from a byte

---
 rtl/shapool_pkg.sv | 18 +
 rtl/shapool_result_tx.sv | 46 ++++
 rtl/shapool_job_ctrl.sv | 151 +++++++++++++++
 tb/tb_shapool_job_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shapool_pkg.sv
// Shared constants for the shapool host-side job controller.
package shapool_pkg;

    localparam int unsigned JOB_BYTES    = 45;
    localparam int unsigned RESULT_BYTES = 5;
    localparam int unsigned JOB_BITS     = JOB_BYTES * 8;
    localparam int unsigned RESULT_BITS  = RESULT_BYTES * 8;

    // Controller FSM encodings
    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    // Result reported when the nonce space is exhausted without a hit
    localparam logic [7:0]  EXHAUST_FLAGS = 8'h00;
    localparam logic [31:0] EXHAUST_NONCE = 32'hFFFF_FFFF;

endpackage

// File: rtl/shapool_result_tx.sv
// Result serialiser: loads a 40-bit frame and emits it MSB byte first over a
// valid/ready byte link, pulsing done on the transfer of the last byte.
module shapool_result_tx
    import shapool_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [RESULT_BITS-1:0] frame,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   done
);

    logic [RESULT_BITS-1:0] shift_q;
    logic [2:0]             cnt_q;
    logic                   valid_q;
    logic                   tx_fire;

    assign tx_fire  = valid_q & tx_ready;
    assign done     = tx_fire && (cnt_q == 3'(RESULT_BYTES - 1));
    assign tx_data  = shift_q[RESULT_BITS-1 -: 8];
    assign tx_valid = valid_q;

    // Load the frame, then shift one byte out per accepted transfer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            shift_q <= frame;
            cnt_q   <= '0;
            valid_q <= 1'b1;
        end else if (tx_fire) begin
            shift_q <= {shift_q[RESULT_BITS-9:0], 8'h00};
            if (done) begin
                valid_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/shapool_job_ctrl.sv
// Host-side job/result controller for shapool: loads a 45-byte job, runs the
// core, captures the first success and returns a 5-byte result frame.
// Optional: define SHAPOOL_CTRL_EXHAUST_EN to report nonce-space exhaustion.
module shapool_job_ctrl
    import shapool_pkg::*;
#(
    parameter int unsigned POOL_SIZE_LOG2 = 1,
    parameter int unsigned NONCE_ADJ      = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         core_reset_n,
    output logic [255:0] sha_state,
    output logic [95:0]  message_head,
    output logic [7:0]   nonce_start_MSB,
    input  logic         core_success,
    input  logic [31:0]  core_nonce,
    input  logic [7:0]   core_match_flags,
    output logic         busy
);

    localparam logic [31:0] NonceAdj = 32'(NONCE_ADJ);

    if (POOL_SIZE_LOG2 < 1 || POOL_SIZE_LOG2 > 31) begin : g_bad_pool_size
        $error("POOL_SIZE_LOG2 must be in 1..31");
    end

    logic [1:0]             state_q;
    logic [5:0]             byte_cnt_q;
    logic                   rx_ready_q;
    logic                   core_reset_n_q;
    logic                   busy_q;
    logic                   first_run_q;
    logic [JOB_BITS-1:0]    job_q;
    logic                   rx_fire;
    logic                   res_load;
    logic [RESULT_BITS-1:0] res_frame;
    logic                   tx_done;

    assign rx_fire = rx_valid & rx_ready_q;

`ifdef SHAPOOL_CTRL_EXHAUST_EN
    logic seen_nz_q;
    logic nonce_low_zero;

    assign nonce_low_zero = (core_nonce[31-POOL_SIZE_LOG2:0] == '0);

    // Remember that the core's lower nonce has left zero during this run
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_nz_q <= 1'b0;
        end else if (state_q != ST_RUN) begin
            seen_nz_q <= 1'b0;
        end else if (!first_run_q && !nonce_low_zero) begin
            seen_nz_q <= 1'b1;
        end
    end
`endif

    // Decide when RUN ends and what result frame to hand to the serialiser
    always_comb begin
        res_load  = 1'b0;
        res_frame = {core_match_flags, core_nonce - NonceAdj};
        // First RUN cycle is skipped: the core is still leaving reset
        if (state_q == ST_RUN && !first_run_q) begin
            if (core_success) begin
                res_load = 1'b1;
`ifdef SHAPOOL_CTRL_EXHAUST_EN
            end else if (seen_nz_q && nonce_low_zero) begin
                res_load  = 1'b1;
                res_frame = {EXHAUST_FLAGS, EXHAUST_NONCE};
`endif
            end
        end
    end

    // Controller FSM, byte counter and job shift register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_LOAD;
            byte_cnt_q     <= '0;
            rx_ready_q     <= 1'b0;
            core_reset_n_q <= 1'b0;
            busy_q         <= 1'b0;
            first_run_q    <= 1'b0;
            job_q          <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    rx_ready_q <= 1'b1;
                    if (rx_fire) begin
                        job_q <= {job_q[JOB_BITS-9:0], rx_data};
                        if (byte_cnt_q == 6'(JOB_BYTES - 1)) begin
                            byte_cnt_q     <= '0;
                            rx_ready_q     <= 1'b0;
                            core_reset_n_q <= 1'b1;
                            busy_q         <= 1'b1;
                            first_run_q    <= 1'b1;
                            state_q        <= ST_RUN;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 6'd1;
                        end
                    end
                end
                ST_RUN: begin
                    first_run_q <= 1'b0;
                    if (res_load) begin
                        core_reset_n_q <= 1'b0;
                        state_q        <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_done) begin
                        busy_q     <= 1'b0;
                        byte_cnt_q <= '0;
                        rx_ready_q <= 1'b1;
                        state_q    <= ST_LOAD;
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

    shapool_result_tx u_result_tx (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (res_load),
        .frame    (res_frame),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (tx_done)
    );

    assign rx_ready        = rx_ready_q;
    assign core_reset_n    = core_reset_n_q;
    assign busy            = busy_q;
    assign sha_state       = job_q[JOB_BITS-1 -: 256];
    assign message_head    = job_q[103:8];
    assign nonce_start_MSB = job_q[7:0];

endmodule

// File: tb/tb_shapool_job_ctrl.sv
// Self-checking bench for shapool_job_ctrl: directed scenarios plus random jobs,
// results and link stalls, compared against a byte-level reference model.
module tb_shapool_job_ctrl;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic         core_reset_n;
    logic [255:0] sha_state;
    logic [95:0]  message_head;
    logic [7:0]   nonce_start_MSB;
    logic         core_success = 1'b0;
    logic [31:0]  core_nonce = 32'h0;
    logic [7:0]   core_match_flags = 8'h00;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  job_b [45];
    logic [39:0] frame;

    shapool_job_ctrl #(
        .POOL_SIZE_LOG2 (1),
        .NONCE_ADJ      (2)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .core_reset_n     (core_reset_n),
        .sha_state        (sha_state),
        .message_head     (message_head),
        .nonce_start_MSB  (nonce_start_MSB),
        .core_success     (core_success),
        .core_nonce       (core_nonce),
        .core_match_flags (core_match_flags),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [359:0] obs, input logic [359:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Job as the host sees it: byte 0 is the most significant byte of the 360-bit word
    function automatic logic [359:0] model_job();
        logic [359:0] v;
        v = '0;
        for (int i = 0; i < 45; i++) v[359-8*i -: 8] = job_b[i];
        return v;
    endfunction

    function automatic logic [39:0] model_result(input logic [31:0] n, input logic [7:0] f);
        return {f, n - 32'd2};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"}, rx_ready, 1'b0);
        check({tag, "_tx_valid"}, tx_valid, 1'b0);
        check({tag, "_tx_data"}, tx_data, 8'h00);
        check({tag, "_core_reset_n"}, core_reset_n, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_job"}, {sha_state, message_head, nonce_start_MSB}, 360'h0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        core_success = 1'b0;
        core_nonce = 32'h0;
        #3;
        check_reset_vals("reset");
        step();
        reset_n = 1'b1;
        step();
        check("rx_ready_after_reset", rx_ready, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        bit   ok;
        ok = 0;
        rx_data = b;
        rx_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            acc = rx_ready;
            step();
            if (acc) begin
                ok = 1;
                break;
            end
        end
        rx_valid = 1'b0;
        rx_data = 8'($urandom);
        if (!ok) begin
            checks++;
            errors++;
            $error("FAIL rx_timeout observed=stalled expected=accepted");
        end
    endtask

    // Stream the first nbytes of job_b, optionally with random idle gaps
    task automatic send_job(input int nbytes, input bit gaps);
        for (int i = 0; i < nbytes; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) step();
            end
            send_byte(job_b[i]);
        end
    endtask

    task automatic check_loaded(input string tag);
        logic [359:0] exp;
        exp = model_job();
        check({tag, "_sha_state"}, sha_state, exp[359:104]);
        check({tag, "_message_head"}, message_head, exp[103:8]);
        check({tag, "_nonce_msb"}, nonce_start_MSB, exp[7:0]);
        check({tag, "_core_reset_n"}, core_reset_n, 1'b1);
        check({tag, "_rx_ready"}, rx_ready, 1'b0);
        check({tag, "_busy"}, busy, 1'b1);
    endtask

    task automatic pulse_success(input logic [31:0] n, input logic [7:0] f);
        core_nonce = n;
        core_match_flags = f;
        core_success = 1'b1;
        step();
        core_success = 1'b0;
        core_nonce = 32'h0;
        core_match_flags = 8'h00;
        check("send_core_reset_n", core_reset_n, 1'b0);
        check("send_tx_valid", tx_valid, 1'b1);
    endtask

    // Collect one result frame; tx_ready low for 'stall' cycles then random
    task automatic recv_frame(input int stall, output logic [39:0] got_frame);
        int         got;
        int         cyc;
        logic       v;
        logic [7:0] d;
        got = 0;
        cyc = 0;
        got_frame = '0;
        while (got < 5 && cyc < 400) begin
            tx_ready = (cyc < stall) ? 1'b0 : 1'($urandom_range(0, 1));
            v = tx_valid;
            d = tx_data;
            step();
            cyc++;
            if (v && tx_ready) begin
                got_frame = {got_frame[31:0], d};
                got++;
            end else if (v) begin
                check("tx_hold", {tx_valid, tx_data}, {1'b1, d});
            end
        end
        tx_ready = 1'b0;
        if (got < 5) begin
            checks++;
            errors++;
            $error("FAIL tx_timeout observed=%0d bytes expected=5 bytes", got);
        end
        check("done_tx_valid", tx_valid, 1'b0);
        check("done_rx_ready", rx_ready, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_core_reset_n", core_reset_n, 1'b0);
        tx_ready = 1'b1;
        repeat (3) step();
        check("no_extra_tx", tx_valid, 1'b0);
        tx_ready = 1'b0;
    endtask

    initial begin
        logic [31:0]  n;
        logic [7:0]   f;
        logic [359:0] held;

        do_reset();

        // 1: incrementing job, no gaps
        for (int i = 0; i < 45; i++) job_b[i] = 8'(i);
        send_job(45, 0);
        check_loaded("t1");
        check("t1_first_byte", sha_state[255:248], 8'h00);
        check("t1_last_byte", nonce_start_MSB, 8'h2C);
        // success during the first RUN cycle is ignored
        core_success = 1'b1;
        core_nonce = 32'h1234_5678;
        step();
        core_success = 1'b0;
        core_nonce = 32'h0;
        check("t1_first_run_ignored", {busy, core_reset_n, tx_valid}, 3'b110);
        // rx traffic in RUN is ignored
        held = {sha_state, message_head, nonce_start_MSB};
        rx_valid = 1'b1;
        rx_data = 8'hAA;
        repeat (3) step();
        rx_valid = 1'b0;
        check("t1_run_rx_ready", rx_ready, 1'b0);
        check("t1_run_job_held", {sha_state, message_head, nonce_start_MSB}, held);

        // 2: success with nonce 0x105 flags 0x02
        pulse_success(32'h0000_0105, 8'h02);
        recv_frame(0, frame);
        check("t2_frame", frame, 40'h02_0000_0103);

        // 3: random job with gaps, long stall on tx
        for (int i = 0; i < 45; i++) job_b[i] = 8'($urandom);
        send_job(45, 1);
        check_loaded("t3");
        step();
        pulse_success(32'h0000_0105, 8'h02);
        recv_frame(7, frame);
        check("t3_frame", frame, model_result(32'h0000_0105, 8'h02));

        // 4: reset after 20 bytes, then reload a fresh job
        for (int i = 0; i < 45; i++) job_b[i] = 8'($urandom);
        send_job(20, 0);
        do_reset();
        for (int i = 0; i < 45; i++) job_b[i] = 8'($urandom);
        send_job(45, 1);
        check_loaded("t4");

        // 5: subtraction wraps below zero
        repeat (2) step();
        pulse_success(32'h0000_0001, 8'h5A);
        recv_frame(2, frame);
        check("t5_frame", frame, 40'h5A_FFFF_FFFF);

        // Random jobs, results and stalls
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 45; i++) job_b[i] = 8'($urandom);
            send_job(45, 1);
            check_loaded("rnd");
            repeat ($urandom_range(1, 5)) step();
            n = $urandom;
            f = 8'($urandom);
            pulse_success(n, f);
            recv_frame(int'($urandom_range(0, 6)), frame);
            check("rnd_frame", frame, model_result(n, f));
        end

        // 6: lower nonce wraps to zero with no success
        for (int i = 0; i < 45; i++) job_b[i] = 8'($urandom);
        send_job(45, 0);
        step();
        core_nonce = 32'h7FFF_FFFF;
        repeat (3) step();
        core_nonce = 32'h0;
`ifdef SHAPOOL_CTRL_EXHAUST_EN
        recv_frame(0, frame);
        check("t6_exhaust_frame", frame, 40'h00_FFFF_FFFF);
`else
        repeat (10) step();
        check("t6_stays_run", {busy, core_reset_n, tx_valid}, 3'b110);
        pulse_success(32'h0000_0010, 8'h81);
        recv_frame(0, frame);
        check("t6_frame", frame, 40'h81_0000_000E);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
